icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, read-only instruction cache between the datapath fetch port and
//  the memory arbiter. Consumes imemREN/imemaddr, returns ihit/imemload. On a miss
//  it fetches one word from memory, fills the frame, then hits. Also keeps hit/miss counters.
// PARAMETERS
//  SETS      16   number of frames (power of 2); index width IDXW = log2(SETS)
//  PC_RESET  0    unused by cache logic; kept for fetch-address bring-up checks only
// PORTS
//  CLK         in   1   system clock, all state on rising edge
//  RST         in   1   asynchronous, active-high reset
//  imemREN     in   1   datapath instruction read request
//  imemaddr    in   32  instruction byte address (word aligned; [1:0] ignored)
//  flush       in   1   synchronous invalidate-all request
//  ihit        out  1   imemload valid this cycle for imemaddr
//  imemload    out  32  instruction word
//  iREN        out  1   memory read request
//  iaddr       out  32  memory read address ({imemaddr[31:2],2'b00})
//  iwait       in   1   memory busy; iload valid in the cycle iwait==0 while iREN==1
//  iload       in   32  memory read data
//  hit_count   out  32  cycles with ihit==1
//  miss_count  out  32  misses started
// BEHAVIOUR
//  Address split: tag=[31:IDXW+2], idx=[IDXW+1:2], byte offset [1:0] ignored.
//  Frame storage: valid bit, tag, 32b data per set; no dirty bit (read-only cache).
//  Reset (async, RST=1): all valid bits 0, FSM=IDLE, counters 0; ihit=0, iREN=0, imemload=0.
//  Lookup is combinational: hit = imemREN & valid[idx] & (tag[idx]==addr tag).
//  ihit=hit only in IDLE; imemload=data[idx] when ihit, else 32'h0.
//  FSM states: IDLE, FETCH.
//   IDLE : imemREN & ~hit & ~flush -> FETCH, miss_count++ . Otherwise stay.
//   FETCH: iREN=1, iaddr=aligned imemaddr, ihit=0.
//          iwait==0 -> write frame (data=iload, tag, valid=1), go IDLE.
//          iwait==1 -> stay.
//  Miss latency: cycles until iwait==0, plus 1 cycle; the hit is seen in IDLE next cycle.
//  Fill-cycle ihit stays 0 even though data is arriving; no bypass of iload.
//  Datapath holds imemaddr until ihit. If imemREN drops in FETCH, the fill still
//  completes to avoid abandoning an in-flight memory transaction.
//  flush: clears every valid bit on the next edge. Flush has priority over a fill
//   write in the same cycle; FETCH with flush -> IDLE, fill discarded, iREN low next cycle.
//  flush in IDLE suppresses miss start that cycle; ihit may still assert combinationally.
//  Counters: hit_count++ every cycle ihit==1; both counters wrap 32'hFFFFFFFF->0.
//  Counters are not cleared by flush.
//  Aliasing: same idx with different tag replaces the frame (conflict miss), no merge.
//  RST asserted in FETCH: immediate IDLE, iREN drops asynchronously, frame not written.
//  No X on outputs after reset; ihit never asserts while iREN==1.
// TESTING
//  1 Cold miss: RST, imemREN=1, addr 0x0000_0040, memory iwait=1 for 3 cycles then
//    iload=0x2001_0005 -> iREN high 4 cycles, ihit=1 next cycle, imemload=0x2001_0005,
//    miss_count=1, hit_count=1.
//  2 Re-read 0x40 over 5 cycles -> ihit=1 every cycle, iREN=0, hit_count+5.
//  3 Conflict: 0x40 then 0x0000_0440 (same idx, SETS=16) then 0x40 ->
//    three misses, miss_count=3, final data matches memory at 0x40.
//  4 Flush: fill 0x40, pulse flush, read 0x40 -> miss, iREN=1; flush during FETCH ->
//    iREN low next cycle, frame stays invalid.
//  5 Async RST mid-FETCH (iwait=1) -> iREN=0, ihit=0 same cycle, counters 0,
//    next read of a prior address misses.
//  6 Random addrs vs reference memory model, 10k requests -> every ihit data correct,
//    hit_count+miss_count matches model.

Source files
------------

// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
// Bundle of the fetch-side and memory-side signals of the direct-mapped
// instruction cache, plus its statistics counters.
//
//   imemREN    datapath read request
//   imemaddr   datapath byte address (word aligned, [1:0] ignored)
//   flush      synchronous invalidate-all request
//   ihit       imemload valid for imemaddr this cycle
//   imemload   instruction word returned to the datapath
//   iREN       memory read request
//   iaddr      memory read address (word aligned)
//   iwait      memory busy; iload valid in a cycle with iREN=1 and iwait=0
//   iload      memory read data
//   hit_count  cycles with ihit=1
//   miss_count misses started
//
// slave  : the cache's view
// master : the view of the environment (datapath + memory arbiter)
// ---------------------------------------------------------------------------
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
// Direct-mapped, read-only instruction cache between the fetch port and the
// memory arbiter. Lookup is combinational; a miss fetches one word, fills the
// frame and returns to IDLE, where the hit is then seen. Hit/miss counters
// are kept for performance monitoring.
//
// Ports
//   CLK   in  system clock, all state on the rising edge
//   RST   in  asynchronous, active-high reset
//   bus   slave side of icache_direct_if (fetch request/response, memory
//         request/response, flush, hit_count/miss_count)
//
// Parameters
//   SETS      number of frames (power of 2, at least 2)
//   PC_RESET  fetch reset address; not used by the cache logic
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int unsigned SETS     = 16,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic           CLK,
    input  logic           RST,
    icache_direct_if.slave bus
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - IDXW - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state, next_state;

    // Frame storage: valid bits are control state and are reset; tag and
    // data are only meaningful under a set valid bit and are never reset.
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];

    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic            hit;
    logic            ihit_c;
    logic            iren_c;
    logic            miss_start;
    logic            fill;
    logic [31:0]     hit_cnt;
    logic [31:0]     miss_cnt;

    // Byte offset and the bring-up reset address take no part in caching.
    logic            unused_bits;
    assign unused_bits = ^{bus.imemaddr[1:0], PC_RESET};

    assign idx = bus.imemaddr[IDXW+1:2];
    assign tag = bus.imemaddr[31:IDXW+2];
    assign hit = bus.imemREN & valid[idx] & (tag_mem[idx] == tag);

    // Next state and outputs
    always_comb begin
        next_state = state;
        ihit_c     = 1'b0;
        iren_c     = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                ihit_c = hit;
                // A flush in the same cycle suppresses the miss; the address
                // is re-looked-up against the emptied cache next cycle.
                if (bus.imemREN && !hit && !bus.flush) begin
                    next_state = FETCH;
                    miss_start = 1'b1;
                end
            end
            FETCH: begin
                iren_c = 1'b1;
                // Flush wins over a completing fill: the arriving word is
                // dropped so no frame survives the invalidate. The fill
                // completes regardless of imemREN so the memory transaction
                // is never abandoned.
                if (bus.flush) begin
                    next_state = IDLE;
                end else if (!bus.iwait) begin
                    next_state = IDLE;
                    fill       = 1'b1;
                end
            end
        endcase
    end

    // No bypass of iload: the filled word is returned from the frame on the
    // following IDLE cycle, so ihit and iREN are never high together.
    assign bus.ihit       = ihit_c;
    assign bus.imemload   = ihit_c ? data_mem[idx] : 32'h0;
    assign bus.iREN       = iren_c;
    assign bus.iaddr      = {bus.imemaddr[31:2], 2'b00};
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // State, valid bits and counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            valid    <= '0;
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            state <= next_state;
            if (bus.flush) begin
                valid <= '0;
            end else if (fill) begin
                valid[idx] <= 1'b1;
            end
            // Counters wrap naturally and are not touched by flush.
            if (ihit_c) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    // Frame tag/data write; fill is already low during reset (state IDLE).
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= bus.iload;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
// Self-checking bench for icache_direct. A memory responder serves iREN with
// a configurable number of busy cycles; a reference model that tracks which
// aligned addresses are resident predicts ihit/imemload/iREN/iaddr and both
// counters every cycle. Directed scenarios pin literal expectations, then
// 10000 random requests exercise hits, conflicts, flushes and dropped REN.
// ---------------------------------------------------------------------------
module tb_icache_direct;
    localparam int SETS = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    icache_direct_if bus ();

    icache_direct #(
        .SETS     (SETS),
        .PC_RESET (32'h0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp   = 0;
    int n_bad   = 0;
    int lat_cfg = 0;

    // Reference memory contents; 0x40 holds the literal word used by the
    // directed cold-miss scenario.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0040) return 32'h2001_0005;
        return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: busy for lat_cfg cycles of each request, then data.
    int wcnt = 0;
    initial begin
        bus.iwait = 1'b1;
        bus.iload = 32'h0;
        forever begin
            @(negedge CLK);
            if (bus.iREN) begin
                if (wcnt > 0) begin
                    bus.iwait = 1'b1;
                    wcnt--;
                end else begin
                    bus.iwait = 1'b0;
                    bus.iload = mem_word(bus.iaddr);
                end
            end else begin
                bus.iwait = 1'b1;
                bus.iload = 32'hDEAD_BEEF;
                wcnt      = lat_cfg;
            end
        end
    end

    // Reference model: which aligned address each set holds, whether a
    // memory fetch is outstanding, and the expected counters.
    bit          m_valid [SETS];
    logic [31:0] m_addr  [SETS];
    bit          m_fill;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    initial begin
        logic [31:0] aa;
        int          si;
        bit          present;
        bit          e_hit;
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                chk("rst_ihit", {31'h0, bus.ihit}, 32'h0);
                chk("rst_iren", {31'h0, bus.iREN}, 32'h0);
                chk("rst_imemload", bus.imemload, 32'h0);
                chk("rst_hit_count", bus.hit_count, 32'h0);
                chk("rst_miss_count", bus.miss_count, 32'h0);
                for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
                m_fill   = 1'b0;
                m_hits   = 32'h0;
                m_misses = 32'h0;
            end else begin
                aa      = {bus.imemaddr[31:2], 2'b00};
                si      = int'((aa >> 2) % SETS);
                present = m_valid[si] && (m_addr[si] == aa);
                e_hit   = !m_fill && bus.imemREN && present;
                chk("ihit", {31'h0, bus.ihit}, {31'h0, e_hit});
                chk("imemload", bus.imemload, e_hit ? mem_word(aa) : 32'h0);
                chk("iren", {31'h0, bus.iREN}, {31'h0, m_fill});
                if (m_fill) chk("iaddr", bus.iaddr, aa);
                chk("hit_count", bus.hit_count, m_hits);
                chk("miss_count", bus.miss_count, m_misses);
                chk("ihit_and_iren", {31'h0, bus.ihit & bus.iREN}, 32'h0);
                // Predict the effect of the coming edge.
                if (e_hit) m_hits++;
                if (bus.flush) begin
                    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
                    m_fill = 1'b0;
                end else if (m_fill) begin
                    if (!bus.iwait) begin
                        m_valid[si] = 1'b1;
                        m_addr[si]  = aa;
                        m_fill      = 1'b0;
                    end
                end else if (bus.imemREN && !present) begin
                    m_fill = 1'b1;
                    m_misses++;
                end
            end
        end
    end

    // Hold address a until ihit; returns the number of cycles iREN was high.
    task automatic request(input logic [31:0] a, input int lat, input bit rnd,
                           output int iren_cyc, output bit got);
        iren_cyc = 0;
        got      = 1'b0;
        lat_cfg  = lat;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge CLK);
            bus.imemaddr = a;
            bus.imemREN  = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            bus.flush    = rnd ? ($urandom_range(0, 40) == 0) : 1'b0;
            #3;
            if (bus.iREN) iren_cyc++;
            if (bus.ihit) got = 1'b1;
        end
        chk("request_done", {31'h0, got}, 32'h1);
    endtask

    initial begin
        int          ic;
        bit          got;
        logic [31:0] a;
        logic [25:0] t;
        logic [3:0]  ix;
        logic [1:0]  off;

        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.flush    = 1'b0;
        RST          = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Cold miss at 0x40: 3 busy cycles then data.
        request(32'h0000_0040, 3, 1'b0, ic, got);
        chk("cold_iren_cycles", 32'(ic), 32'd4);
        chk("cold_ihit", {31'h0, bus.ihit}, 32'h1);
        chk("cold_data", bus.imemload, 32'h2001_0005);
        chk("cold_miss_count", bus.miss_count, 32'd1);

        // Re-read 0x40 for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            bus.imemREN = 1'b1;
            #3;
            chk("reread_ihit", {31'h0, bus.ihit}, 32'h1);
            chk("reread_iren", {31'h0, bus.iREN}, 32'h0);
            if (k == 0) chk("cold_hit_count", bus.hit_count, 32'd1);
        end
        @(negedge CLK);
        bus.imemREN = 1'b0;
        #3;
        chk("reread_hit_count", bus.hit_count, 32'd6);

        // Conflict: 0x440 shares set 0 with 0x40.
        request(32'h0000_0440, 2, 1'b0, ic, got);
        chk("conflict_440_iren", 32'(ic), 32'd3);
        chk("conflict_440_data", bus.imemload, mem_word(32'h0000_0440));
        request(32'h0000_0040, 1, 1'b0, ic, got);
        chk("conflict_40_iren", 32'(ic), 32'd2);
        chk("conflict_miss_count", bus.miss_count, 32'd3);
        chk("conflict_40_data", bus.imemload, 32'h2001_0005);

        // Flush, re-read misses, flush again mid-fetch.
        lat_cfg = 6;
        @(negedge CLK);
        bus.imemREN = 1'b0;
        bus.flush   = 1'b1;
        #3;
        @(negedge CLK);
        bus.flush    = 1'b0;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        #3;
        chk("flush_reread_ihit", {31'h0, bus.ihit}, 32'h0);
        @(negedge CLK);
        #3;
        chk("flush_reread_iren", {31'h0, bus.iREN}, 32'h1);
        chk("flush_miss_count", bus.miss_count, 32'd4);
        @(negedge CLK);
        bus.flush = 1'b1;
        #3;
        @(negedge CLK);
        bus.flush = 1'b0;
        #3;
        chk("flush_fetch_iren", {31'h0, bus.iREN}, 32'h0);
        chk("flush_fetch_ihit", {31'h0, bus.ihit}, 32'h0);
        request(32'h0000_0040, 0, 1'b0, ic, got);
        chk("flush_refill_miss_count", bus.miss_count, 32'd5);
        chk("flush_refill_data", bus.imemload, 32'h2001_0005);

        // Asynchronous reset in the middle of a fetch.
        lat_cfg = 20;
        @(negedge CLK);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0080;
        #3;
        @(negedge CLK);
        #3;
        chk("pre_rst_iren", {31'h0, bus.iREN}, 32'h1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_iren", {31'h0, bus.iREN}, 32'h0);
        chk("async_rst_ihit", {31'h0, bus.ihit}, 32'h0);
        chk("async_rst_hit_count", bus.hit_count, 32'h0);
        chk("async_rst_miss_count", bus.miss_count, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST         = 1'b0;
        bus.imemREN = 1'b0;
        request(32'h0000_0040, 1, 1'b0, ic, got);
        chk("post_rst_iren", 32'(ic), 32'd2);
        chk("post_rst_miss_count", bus.miss_count, 32'd1);

        // Random requests; exactly one hit cycle ends each request.
        for (int r = 0; r < 10000; r++) begin
            if ($urandom_range(0, 15) == 0) t = 26'($urandom);
            else                            t = 26'($urandom_range(0, 1));
            ix  = 4'($urandom_range(0, 15));
            off = 2'($urandom_range(0, 3));
            a   = {t, ix, off};
            request(a, $urandom_range(0, 3), 1'b1, ic, got);
        end
        @(negedge CLK);
        bus.imemREN = 1'b0;
        bus.flush   = 1'b0;
        #3;
        chk("random_hit_total", bus.hit_count, 32'd10001);
        chk("random_sum_total", bus.hit_count + bus.miss_count, m_hits + m_misses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
